// File: rtl/hart_seq.sv
// rtl/hart_seq.sv - multi-cycle sequencer sharing one bus port between fetch and load/store
// Optional: define HART_SEQ_ALIGN_TRAP_EN to trap (halt, trap=1) on misaligned fetch or data access.
module hart_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [31:0] insn,
  input  logic [31:0] nextpc,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwdata,
  input  logic        memw,
  input  logic        memsext,
  input  logic [1:0]  memwidth,
  output logic [31:0] memrdata,
  output logic        commit,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        halt_req,
  output logic        halted,
  output logic [31:0] instret
`ifdef HART_SEQ_ALIGN_TRAP_EN
  ,
  output logic        trap
`endif
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] memrdata_q, memrdata_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;

  logic        retire;
  logic        is_mem_op;
  logic        fetch_mis, data_mis;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;

  assign is_mem_op = (insn_q[6:0] == 7'b0000011) || (insn_q[6:0] == 7'b0100011);

  always_comb begin
    fetch_mis = 1'b0;
    data_mis  = 1'b0;
`ifdef HART_SEQ_ALIGN_TRAP_EN
    fetch_mis = (pc_q[1:0] != 2'b00);
    data_mis  = ((memwidth == 2'd1) && memaddr[0]) ||
                (memwidth[1] && (memaddr[1:0] != 2'b00));
`endif
  end

  // Byte-lane steering; memwidth=3 behaves as a word access.
  always_comb begin
    lane_be    = 4'hF;
    lane_wdata = memwdata;
    case (memwidth)
      2'd0: begin
        lane_be    = 4'b0001 << memaddr[1:0];
        lane_wdata = {4{memwdata[7:0]}};
      end
      2'd1: begin
        lane_be    = 4'b0011 << {memaddr[1], 1'b0};
        lane_wdata = {2{memwdata[15:0]}};
      end
      default: begin
        lane_be    = 4'hF;
        lane_wdata = memwdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (memaddr[1:0])
      2'd0: ld_byte = bus_rdata[7:0];
      2'd1: ld_byte = bus_rdata[15:8];
      2'd2: ld_byte = bus_rdata[23:16];
      2'd3: ld_byte = bus_rdata[31:24];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = memaddr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (memwidth)
      2'd0:    load_val = {{24{memsext & ld_byte[7]}}, ld_byte};
      2'd1:    load_val = {{16{memsext & ld_half[15]}}, ld_half};
      default: load_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      insn_q     <= NOP_INSN;
      memrdata_q <= 32'h0;
      instret_q  <= 32'h0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      insn_q     <= insn_d;
      memrdata_q <= memrdata_d;
      instret_q  <= instret_d;
      trap_q     <= trap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    memrdata_d = memrdata_q;
    instret_d  = instret_q;
    trap_d     = trap_q;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_mis) begin
          trap_d  = 1'b1;
          state_d = S_HALT;
        end else if (bus_ready) begin
          insn_d  = bus_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_op) state_d = S_MEM;
        else           retire  = 1'b1;
      end
      S_MEM: begin
        if (data_mis) begin
          trap_d  = 1'b1;
          state_d = S_HALT;
        end else if (bus_ready) begin
          if (memw) begin
            retire = 1'b1;
          end else begin
            memrdata_d = load_val;
            state_d    = S_WB;
          end
        end
      end
      S_WB:   retire = 1'b1;
      S_HALT: begin
        // A trap is sticky until reset; a plain halt resumes when released.
        if (!halt_req && !trap_q) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (retire) begin
      pc_d      = nextpc;
      instret_d = instret_q + 32'd1;
      state_d   = halt_req ? S_HALT : S_FETCH;
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = {pc_q[31:2], 2'b00};
    bus_be    = 4'h0;
    bus_wdata = 32'h0;
    case (state_q)
      S_FETCH: begin
        bus_req = !fetch_mis;
        bus_be  = 4'hF;
      end
      S_MEM: begin
        bus_req   = !data_mis;
        bus_we    = memw;
        bus_addr  = {memaddr[31:2], 2'b00};
        bus_be    = lane_be;
        bus_wdata = lane_wdata;
      end
      default: ;
    endcase
    // Reset abandons any transfer in flight within the same cycle.
    if (reset) begin
      bus_req = 1'b0;
      bus_we  = 1'b0;
      bus_be  = 4'h0;
    end
    commit = retire && !reset;
    halted = (state_q == S_HALT);
  end

  assign pc       = pc_q;
  assign insn     = insn_q;
  assign memrdata = memrdata_q;
  assign instret  = instret_q;
`ifdef HART_SEQ_ALIGN_TRAP_EN
  assign trap     = trap_q;
`endif

endmodule

// File: tb/tb_hart_seq.sv
// tb/tb_hart_seq.sv - directed self-checking bench for hart_seq
// Trap checks are built only when HART_SEQ_ALIGN_TRAP_EN is defined.
module tb_hart_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, insn, nextpc, memaddr, memwdata, memrdata;
  logic        memw, memsext;
  logic [1:0]  memwidth;
  logic        commit, bus_req, bus_we, bus_ready, halt_req, halted;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, instret;
  logic [3:0]  bus_be;
`ifdef HART_SEQ_ALIGN_TRAP_EN
  logic        trap;
`endif

  int errors = 0;
  int checks = 0;

  hart_seq dut (
    .clk(clk), .reset(reset), .pc(pc), .insn(insn), .nextpc(nextpc),
    .memaddr(memaddr), .memwdata(memwdata), .memw(memw), .memsext(memsext),
    .memwidth(memwidth), .memrdata(memrdata), .commit(commit),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .halt_req(halt_req), .halted(halted), .instret(instret)
`ifdef HART_SEQ_ALIGN_TRAP_EN
    , .trap(trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its FETCH cycle through commit, acting as the bus.
  task automatic run_insn(input string tag, input logic [31:0] iw, input int dly,
                          input logic [31:0] rdata, input logic [31:0] exp_pc,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic exp_we, input logic [31:0] exp_wd,
                          input int exp_cyc, input logic [31:0] exp_instret);
    int cyc = 0, xfer = 0, waitc = 0, ncom = 0;
    for (int i = 0; i < 60; i++) begin
      cyc++;
      bus_ready = 1'b0;
      #1;
      if (bus_req) begin
        if (xfer == 0) begin
          check({tag, " fetch addr"}, bus_addr, exp_pc);
          check({tag, " fetch be"}, {28'h0, bus_be}, 32'hF);
          check({tag, " fetch we"}, {31'h0, bus_we}, 32'h0);
        end else begin
          check({tag, " data addr"}, bus_addr, exp_addr);
          check({tag, " data be"}, {28'h0, bus_be}, {28'h0, exp_be});
          check({tag, " data we"}, {31'h0, bus_we}, {31'h0, exp_we});
          if (exp_we) check({tag, " data wdata"}, bus_wdata, exp_wd);
        end
        if (waitc == dly) begin
          bus_ready = 1'b1;
          bus_rdata = (xfer == 0) ? iw : rdata;
          waitc = 0;
          xfer++;
        end else begin
          waitc++;
        end
      end
      #1;
      if (commit) ncom++;
      tick();
      if (ncom != 0) break;
    end
    bus_ready = 1'b0;
    check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " commits"}, ncom, 1);
    check({tag, " commit drop"}, {31'h0, commit}, 32'h0);
    check({tag, " pc"}, pc, nextpc);
    check({tag, " instret"}, instret, exp_instret);
  endtask

  initial begin
    reset = 1'b1; bus_ready = 1'b0; bus_rdata = 32'h0; halt_req = 1'b0;
    nextpc = 32'h0; memaddr = 32'h0; memwdata = 32'h0; memw = 1'b0;
    memsext = 1'b0; memwidth = 2'd0;
    tick(); tick();
    check("rst pc", pc, 32'h0);
    check("rst insn", insn, 32'h13);
    check("rst bus_req", {31'h0, bus_req}, 32'h0);
    check("rst commit", {31'h0, commit}, 32'h0);
    check("rst halted", {31'h0, halted}, 32'h0);
    check("rst instret", instret, 32'h0);
    check("rst memrdata", memrdata, 32'h0);
    reset = 1'b0;

    nextpc = 32'h4;
    run_insn("addi", 32'h00500093, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 2, 32'd1);
    check("addi insn", insn, 32'h00500093);

    nextpc = 32'h8; memaddr = 32'h103; memwidth = 2'd0; memsext = 1'b1;
    run_insn("lb", 32'h00000003, 0, 32'h80123456, 32'h4, 32'h100, 4'b1000, 1'b0, 32'h0, 4, 32'd2);
    check("lb memrdata", memrdata, 32'hFFFFFF80);

    nextpc = 32'hC; memsext = 1'b0;
    run_insn("lbu", 32'h00004003, 0, 32'h80123456, 32'h8, 32'h100, 4'b1000, 1'b0, 32'h0, 4, 32'd3);
    check("lbu memrdata", memrdata, 32'h00000080);

    nextpc = 32'h10; memaddr = 32'h202; memwidth = 2'd1; memw = 1'b1; memwdata = 32'h0000BEEF;
    run_insn("sh", 32'h00000023, 0, 32'h0, 32'hC, 32'h200, 4'b1100, 1'b1, 32'hBEEFBEEF, 3, 32'd4);

    nextpc = 32'h14; memaddr = 32'h102; memw = 1'b0; memsext = 1'b1;
    run_insn("lh", 32'h00001003, 0, 32'h80011234, 32'h10, 32'h100, 4'b1100, 1'b0, 32'h0, 4, 32'd5);
    check("lh memrdata", memrdata, 32'hFFFF8001);

    nextpc = 32'h18; memaddr = 32'h300; memwidth = 2'd3; memsext = 1'b0;
    run_insn("lw slow", 32'h00002003, 3, 32'hCAFEF00D, 32'h14, 32'h300, 4'hF, 1'b0, 32'h0, 10, 32'd6);
    check("lw slow memrdata", memrdata, 32'hCAFEF00D);

    nextpc = 32'h40; memaddr = 32'h304; memwidth = 2'd2; halt_req = 1'b1;
    run_insn("lw halt", 32'h00002003, 0, 32'h12345678, 32'h18, 32'h304, 4'hF, 1'b0, 32'h0, 4, 32'd7);
    check("halt halted", {31'h0, halted}, 32'h1);
    check("halt bus_req", {31'h0, bus_req}, 32'h0);
    tick(); tick();
    check("halt held", {31'h0, halted}, 32'h1);
    halt_req = 1'b0;
    tick();
    check("resume halted", {31'h0, halted}, 32'h0);
    check("resume bus_req", {31'h0, bus_req}, 32'h1);
    check("resume addr", bus_addr, 32'h40);

    // Reset while a load is waiting in MEM with ready about to arrive.
    bus_ready = 1'b1; bus_rdata = 32'h00002003; memaddr = 32'h400;
    tick();
    bus_ready = 1'b0;
    tick();
    check("mem bus_req", {31'h0, bus_req}, 32'h1);
    reset = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h0;
    #1;
    check("rst-mid commit", {31'h0, commit}, 32'h0);
    tick();
    check("rst-mid bus_req", {31'h0, bus_req}, 32'h0);
    check("rst-mid pc", pc, 32'h0);
    check("rst-mid instret", instret, 32'h0);
    check("rst-mid commit2", {31'h0, commit}, 32'h0);
    reset = 1'b0; bus_ready = 1'b0;

`ifdef HART_SEQ_ALIGN_TRAP_EN
    bus_ready = 1'b1; bus_rdata = 32'h00002003; memaddr = 32'h101; memwidth = 2'd2; nextpc = 32'h4;
    tick();
    bus_ready = 1'b0;
    check("trap pre", {31'h0, trap}, 32'h0);
    tick();
    check("trap mem bus_req", {31'h0, bus_req}, 32'h0);
    check("trap mem commit", {31'h0, commit}, 32'h0);
    tick();
    check("trap flag", {31'h0, trap}, 32'h1);
    check("trap halted", {31'h0, halted}, 32'h1);
    check("trap bus_req", {31'h0, bus_req}, 32'h0);
    check("trap pc", pc, 32'h0);
    check("trap instret", instret, 32'h0);
    tick();
    check("trap sticky", {31'h0, halted}, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
